// File: rtl/sram_table_arb_if.sv
// Request/response bundle for the segment-table arbiter: AW/AR lookup ports,
// the config port, the SRAM macro port and the init_done status flag.
interface sram_table_arb_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 23
);
  logic              aw_req;
  logic [ADDR_W-1:0] aw_addr;
  logic              aw_gnt;
  logic              aw_rsp_valid;
  logic [DATA_W-1:0] aw_rsp_data;

  logic              ar_req;
  logic [ADDR_W-1:0] ar_addr;
  logic              ar_gnt;
  logic              ar_rsp_valid;
  logic [DATA_W-1:0] ar_rsp_data;

  logic              cfg_req;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              cfg_gnt;
  logic              cfg_rvalid;
  logic [DATA_W-1:0] cfg_rdata;

  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  logic              init_done;

  // The arbiter side.
  modport slave (
    input  aw_req, aw_addr, ar_req, ar_addr,
    input  cfg_req, cfg_we, cfg_addr, cfg_wdata, sram_rdata,
    output aw_gnt, aw_rsp_valid, aw_rsp_data,
    output ar_gnt, ar_rsp_valid, ar_rsp_data,
    output cfg_gnt, cfg_rvalid, cfg_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata, init_done
  );

  // The requesters plus the SRAM macro.
  modport master (
    output aw_req, aw_addr, ar_req, ar_addr,
    output cfg_req, cfg_we, cfg_addr, cfg_wdata, sram_rdata,
    input  aw_gnt, aw_rsp_valid, aw_rsp_data,
    input  ar_gnt, ar_rsp_valid, ar_rsp_data,
    input  cfg_gnt, cfg_rvalid, cfg_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata, init_done
  );
endinterface

// File: rtl/sram_table_arb.sv
// Single-port SRAM segment-table arbiter: clears the table after reset, then
// shares the SRAM between cfg and AW/AR lookups. Optional: SRAM_TABLE_ARB_STATS_EN.
module sram_table_arb #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 23,
  parameter int INIT_DEPTH = 2**ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  sram_table_arb_if.slave    bus
`ifdef SRAM_TABLE_ARB_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [15:0]        stat_conflicts
`endif
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(INIT_DEPTH - 1);
  localparam logic [2:0]        STARVE_LIMIT = 3'd4;

  state_e            state;
  logic [ADDR_W-1:0] init_idx;
  logic              init_go;
  logic              init_done_q;
  logic [2:0]        starve_cnt;
  logic              rr_ptr;       // 0: AW has priority, 1: AR has priority
  logic              aw_rv, ar_rv, cfg_rv;

  logic in_run, lookup_pend, force_lookup;
  logic gnt_aw, gnt_ar, gnt_cfg;

  assign in_run       = (state == ST_RUN);
  assign lookup_pend  = bus.aw_req | bus.ar_req;
  assign force_lookup = lookup_pend && (starve_cnt == STARVE_LIMIT);

  assign gnt_cfg = in_run && bus.cfg_req && !force_lookup;
  assign gnt_aw  = in_run && !gnt_cfg && bus.aw_req && (!bus.ar_req || !rr_ptr);
  assign gnt_ar  = in_run && !gnt_cfg && bus.ar_req && (!bus.aw_req ||  rr_ptr);

  assign bus.aw_gnt  = gnt_aw;
  assign bus.ar_gnt  = gnt_ar;
  assign bus.cfg_gnt = gnt_cfg;

  // init_go holds off the clear sweep for the first cycle after reset, so the
  // SRAM port stays quiet while rst_n is low.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    bus.sram_en    = 1'b0;
    bus.sram_we    = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (state == ST_INIT && init_go) begin
      bus.sram_en   = 1'b1;
      bus.sram_we   = 1'b1;
      bus.sram_addr = init_idx;
    end else if (gnt_cfg) begin
      bus.sram_en    = 1'b1;
      bus.sram_we    = bus.cfg_we;
      bus.sram_addr  = bus.cfg_addr;
      bus.sram_wdata = bus.cfg_we ? bus.cfg_wdata : '0;
    end else if (gnt_aw) begin
      bus.sram_en   = 1'b1;
      bus.sram_addr = bus.aw_addr;
    end else if (gnt_ar) begin
      bus.sram_en   = 1'b1;
      bus.sram_addr = bus.ar_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      init_idx    <= '0;
      init_go     <= 1'b0;
      init_done_q <= 1'b0;
      starve_cnt  <= '0;
      rr_ptr      <= 1'b0;
      aw_rv       <= 1'b0;
      ar_rv       <= 1'b0;
      cfg_rv      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      init_go <= 1'b1;
      aw_rv   <= gnt_aw;
      ar_rv   <= gnt_ar;
      cfg_rv  <= gnt_cfg && !bus.cfg_we;
      case (state)
        ST_INIT: begin
          if (init_go) begin
            if (init_idx == LAST_IDX) begin
              state       <= ST_RUN;
              init_done_q <= 1'b1;
              init_idx    <= '0;
            end else begin
              init_idx <= init_idx + 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Starvation counter tracks cfg wins against a waiting lookup.
          if (gnt_aw || gnt_ar) begin
            starve_cnt <= '0;
            rr_ptr     <= gnt_aw;
          end else if (!lookup_pend) begin
            starve_cnt <= '0;
          end else if (gnt_cfg) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.init_done    = init_done_q;
  assign bus.aw_rsp_valid = aw_rv;
  assign bus.ar_rsp_valid = ar_rv;
  assign bus.cfg_rvalid   = cfg_rv;
  assign bus.aw_rsp_data  = aw_rv  ? bus.sram_rdata : '0;
  assign bus.ar_rsp_data  = ar_rv  ? bus.sram_rdata : '0;
  assign bus.cfg_rdata    = cfg_rv ? bus.sram_rdata : '0;

`ifdef SRAM_TABLE_ARB_STATS_EN
  logic [15:0] conflict_cnt;
  logic        multi_req;

  assign multi_req = (bus.aw_req & bus.ar_req) | (bus.aw_req & bus.cfg_req) |
                     (bus.ar_req & bus.cfg_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (stat_clr) begin
      conflict_cnt <= '0;
    end else if (in_run && multi_req && conflict_cnt != 16'hFFFF) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  assign stat_conflicts = conflict_cnt;
`endif

endmodule

// File: doc/sram_table_arb.md
SRAM_TABLE_ARB -- requirements
Module: sram_table_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, segment-table index width.
REQ-002 SHALL have parameter DATA_W, default 23, entry width ([22] write-perm, [21] read-perm, [20:0] PSA).
REQ-003 SHALL have parameter INIT_DEPTH, default 2**ADDR_W, number of entries cleared after reset.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have AW lookup ports: aw_req in 1; aw_addr in ADDR_W; aw_gnt out 1; aw_rsp_valid out 1; aw_rsp_data out DATA_W.
REQ-006 SHALL have AR lookup ports: ar_req in 1; ar_addr in ADDR_W; ar_gnt out 1; ar_rsp_valid out 1; ar_rsp_data out DATA_W.
REQ-007 SHALL have config ports: cfg_req in 1; cfg_we in 1; cfg_addr in ADDR_W; cfg_wdata in DATA_W; cfg_gnt out 1; cfg_rvalid out 1; cfg_rdata out DATA_W.
REQ-008 SHALL have SRAM ports: sram_en out 1; sram_we out 1; sram_addr out ADDR_W; sram_wdata out DATA_W; sram_rdata in DATA_W (valid one cycle after sram_en with sram_we=0).
REQ-009 SHALL have init_done out 1, high once the table clear has finished.

Function
REQ-010 SHALL implement states INIT and RUN; reset enters INIT.
REQ-011 In INIT, SHALL write 0 to entries 0..INIT_DEPTH-1, one per cycle, using an index counter; all gnt outputs stay 0.
REQ-012 After writing entry INIT_DEPTH-1, SHALL enter RUN next cycle and set init_done=1 until reset.
REQ-013 In RUN, SHALL grant at most one requester per cycle; gnt is combinational from req in the same cycle.
REQ-014 Requesters SHALL hold req, addr and data stable until gnt; the arbiter does not latch ungranted requests.
REQ-015 Priority SHALL be cfg over lookups, except REQ-016.
REQ-016 After 4 consecutive cfg grants while any lookup req is pending, the next cycle SHALL grant a lookup, not cfg; the counter resets on any lookup grant or when no lookup is pending.
REQ-017 AW vs AR SHALL be round-robin: a 1-bit pointer, initially AW, gives priority to the requester not granted last.
REQ-018 On a grant, SHALL drive sram_en=1, sram_addr from the granted port and sram_we=cfg_we for cfg (0 for lookups), in the same cycle.
REQ-019 SHALL assert the granted port's rsp_valid/cfg_rvalid for exactly one cycle, one cycle after a read grant, with data = sram_rdata; no valid for cfg writes.
REQ-020 Response data outputs SHALL be 0 when their valid is 0.
REQ-021 A cfg write at cycle N followed by a lookup of the same address at N+1 SHALL return the newly written data.
REQ-022 With no grant, sram_en=0 and sram_addr/sram_wdata=0.

Reset
REQ-023 rst_n low SHALL asynchronously clear state to INIT, init counter, starvation counter and RR pointer to 0, and all outputs to 0.
REQ-024 Reset during INIT or RUN SHALL discard in-flight responses and restart the full clear sweep.

Configuration
REQ-025 Macro SRAM_TABLE_ARB_STATS_EN defined: SHALL add input stat_clr (1) and output stat_conflicts (16), a saturating count of RUN cycles with at least two reqs asserted; it clears on stat_clr or reset and saturates at 16'hFFFF.
REQ-026 Without SRAM_TABLE_ARB_STATS_EN: no stat ports and no counter logic; all other behaviour identical.

Verification
REQ-027 INIT_DEPTH=8, release reset -> 8 SRAM writes of 0 to addresses 0..7, then init_done=1 at cycle 9; aw_req held during INIT gets aw_gnt only after init_done.
REQ-028 cfg write addr 0x0005 data 0x600123, next cycle aw_req addr 0x0005 -> aw_rsp_valid one cycle after grant with data 0x600123.
REQ-029 aw_req and ar_req held together for 4 cycles -> grants AW,AR,AW,AR; each rsp_valid follows its grant by 1 cycle.
REQ-030 cfg_req held 6 cycles with ar_req held -> cfg granted 4 times, then ar_gnt, then cfg.
REQ-031 Reset asserted one cycle after ar grant -> no ar_rsp_valid; state INIT and init_done=0 immediately.
REQ-032 With SRAM_TABLE_ARB_STATS_EN, 3 conflict cycles -> stat_conflicts=3; stat_clr pulse -> 0.
